// File: rtl/multicycle_rca_pkg.sv
// multicycle_rca_pkg: shared FSM state type for the multicycle ripple-carry adder
package multicycle_rca_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/multicycle_rca_chunk_adder.sv
// chunk_adder: combinational W-bit ripple adder exposing carry-out and carry into the top bit
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar g = 0; g < W; g++) begin : g_fa
    assign s[g]   = a[g] ^ b[g] ^ c[g];
    assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
  end
  assign cout  = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/multicycle_rca.sv
// multicycle_rca: add/sub that ripples CHUNK bits per cycle through one shared chunk adder
module multicycle_rca
  import multicycle_rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CHUNK-1:0] ca, cb, cs;
  logic cc, cm, last;
  assign ca = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign cb = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign last = idx_q == IDX_W'(NUM_CHUNKS - 1);
  chunk_adder #(.W(CHUNK)) u_add (
    .a    (ca),
    .b    (cb),
    .cin  (carry_q),
    .s    (cs),
    .cout (cc),
    .c_msb(cm)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = cin ^ sub;
      idx_d   = '0;
      sum_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      sum_d[int'(idx_q)*CHUNK +: CHUNK] = cs;
      carry_d = cc;
      idx_d   = last ? '0 : idx_q + 1'b1;
      state_d = last ? DONE : RUN;
      cout_d  = last ? cc : cout_q;
      ovf_d   = last ? cm ^ cc : ovf_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_multicycle_rca.sv
// tb_multicycle_rca: directed and random checks of CHUNK=4/16/1 instances against an arithmetic model
module tb_multicycle_rca;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv[3], ir[3], ov[3], ordy[3], cin_i[3], sub_i[3], co[3], of[3];
  logic [15:0] a_i[3], b_i[3], s_o[3];
  int checks = 0, errors = 0, cyc = 0;
  bit en = 1'b0;
  bit busy[3];
  int due[3];
  logic [15:0] e_sum[3];
  logic e_co[3], e_of[3];
  logic [15:0] sp[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_rca #(.WIDTH(16), .CHUNK(g == 0 ? 4 : g == 1 ? 16 : 1)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .a        (a_i[g]),
      .b        (b_i[g]),
      .cin      (cin_i[g]),
      .sub      (sub_i[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .sum      (s_o[g]),
      .cout     (co[g]),
      .ovf      (of[g])
    );
  end
  function automatic int nch(int d);
    return d == 0 ? 4 : d == 1 ? 1 : 16;
  endfunction
  function automatic logic [17:0] ref_op(logic [15:0] a, logic [15:0] b, logic c, logic s);
    int r, sr;
    logic co_r;
    if (!s) begin
      r    = int'(a) + int'(b) + int'(c);
      sr   = int'($signed(a)) + int'($signed(b)) + int'(c);
      co_r = r > 65535;
    end else begin
      r    = int'(a) - int'(b) - int'(c);
      sr   = int'($signed(a)) - int'($signed(b)) - int'(c);
      co_r = r >= 0;
    end
    return {co_r, (sr > 32767 || sr < -32768), r[15:0]};
  endfunction
  task automatic chk(int d, string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d act=%0h exp=%0h", n, d, cyc, act, exp);
    end
  endtask
  always @(posedge clk) begin
    logic [17:0] r;
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        busy[d] = 1'b0;
        e_sum[d] = '0;
        e_co[d] = 1'b0;
        e_of[d] = 1'b0;
      end else if (!busy[d] && iv[d]) begin
        r = ref_op(a_i[d], b_i[d], cin_i[d], sub_i[d]);
        busy[d] = 1'b1;
        due[d] = cyc + nch(d);
        {e_co[d], e_of[d], e_sum[d]} = r;
      end else if (busy[d] && cyc > due[d] && ordy[d]) begin
        busy[d] = 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    if (en) begin
      for (int d = 0; d < 3; d++) begin
        chk(d, "in_ready", ir[d], !busy[d]);
        chk(d, "out_valid", ov[d], busy[d] && cyc >= due[d]);
        if (!busy[d] || cyc >= due[d]) begin
          chk(d, "sum", s_o[d], e_sum[d]);
          chk(d, "cout", co[d], e_co[d]);
          chk(d, "ovf", of[d], e_of[d]);
        end
      end
    end
  end
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, input int hold, input bit poke, output logic [15:0] rs,
                        output logic rc, output logic ro, output int lat);
    int k, t;
    @(negedge clk);
    a_i[d] = a;
    b_i[d] = b;
    cin_i[d] = c;
    sub_i[d] = s;
    iv[d] = 1'b1;
    ordy[d] = 1'b0;
    @(negedge clk);
    k = cyc;
    iv[d] = 1'b0;
    a_i[d] = 16'($urandom);
    b_i[d] = 16'($urandom);
    cin_i[d] = 1'($urandom);
    sub_i[d] = 1'($urandom);
    t = 0;
    while (!ov[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ov[d]) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d waiting for out_valid", d);
    end
    lat = cyc - k;
    rs = s_o[d];
    rc = co[d];
    ro = of[d];
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        iv[d] = 1'b1;
        a_i[d] = 16'($urandom);
      end
      @(negedge clk);
      if (poke) begin
        chk(d, "hold out_valid", ov[d], 1);
        chk(d, "hold sum", s_o[d], rs);
        chk(d, "hold cout", co[d], rc);
        chk(d, "hold ovf", of[d], ro);
        chk(d, "hold in_ready", ir[d], 0);
      end
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    if (poke) begin
      chk(d, "release in_ready", ir[d], 1);
      chk(d, "release out_valid", ov[d], 0);
    end
  endtask
  function automatic logic [15:0] pick();
    return $urandom_range(0, 7) == 0 ? sp[$urandom_range(0, 3)] : 16'($urandom);
  endfunction
  initial begin
    logic [15:0] rs;
    logic rc, ro;
    int lat;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b0;
      cin_i[d] = 1'b0;
      sub_i[d] = 1'b0;
      a_i[d] = '0;
      b_i[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    chk(0, "reset in_ready", ir[0], 1);
    chk(0, "reset sum", s_o[0], 0);
    run_op(0, 16'h00FF, 16'h0001, 0, 0, 0, 0, rs, rc, ro, lat);
    chk(0, "add00FF latency", lat, 4);
    chk(0, "add00FF sum", rs, 16'h0100);
    chk(0, "add00FF cout", rc, 0);
    chk(0, "add00FF ovf", ro, 0);
    run_op(0, 16'hFFFF, 16'h0001, 0, 0, 0, 0, rs, rc, ro, lat);
    chk(0, "addFFFF sum", rs, 16'h0000);
    chk(0, "addFFFF cout", rc, 1);
    chk(0, "addFFFF ovf", ro, 0);
    run_op(0, 16'h7FFF, 16'h0001, 0, 0, 0, 0, rs, rc, ro, lat);
    chk(0, "add7FFF sum", rs, 16'h8000);
    chk(0, "add7FFF cout", rc, 0);
    chk(0, "add7FFF ovf", ro, 1);
    run_op(0, 16'h0005, 16'h0007, 0, 1, 0, 0, rs, rc, ro, lat);
    chk(0, "sub5-7 sum", rs, 16'hFFFE);
    chk(0, "sub5-7 cout", rc, 0);
    chk(0, "sub5-7 ovf", ro, 0);
    run_op(0, 16'h8000, 16'h0001, 0, 1, 10, 1, rs, rc, ro, lat);
    chk(0, "sub8000 sum", rs, 16'h7FFF);
    chk(0, "sub8000 cout", rc, 1);
    chk(0, "sub8000 ovf", ro, 1);
    @(negedge clk);
    a_i[0] = 16'h4321;
    b_i[0] = 16'h1111;
    sub_i[0] = 1'b0;
    cin_i[0] = 1'b0;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(0, "abort in_ready", ir[0], 1);
    chk(0, "abort out_valid", ov[0], 0);
    chk(0, "abort sum", s_o[0], 0);
    run_op(0, 16'h1234, 16'h1111, 0, 0, 0, 0, rs, rc, ro, lat);
    chk(0, "post-abort sum", rs, 16'h2345);
    chk(0, "post-abort cout", rc, 0);
    for (int d = 1; d < 3; d++) begin
      for (int n = 0; n < 1000; n++) begin
        run_op(d, pick(), pick(), 1'($urandom), 1'($urandom), $urandom_range(0, 2), 0,
               rs, rc, ro, lat);
        chk(d, "sweep latency", lat, nch(d));
      end
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_rca.md
MULTICYCLE_RCA -- requirements
Module: multicycle_rca

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits added per RUN cycle; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH are required.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in (add) or borrow-in (sub).
REQ-009 The block SHALL have port sub, input, 1 bit: 0 = a+b+cin, 1 = a-b-cin.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of MSB; for sub, 1 = no borrow.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; NUM_CHUNKS = WIDTH/CHUNK.
REQ-016 in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE.
REQ-017 On accept (in_valid && in_ready), the block SHALL, at that edge: latch a into the A register; latch b, or ~b if sub=1, into the B register; load carry = cin ^ sub; clear the chunk index; clear sum; go to RUN.
REQ-018 Each RUN cycle SHALL add chunk[idx] of A and B plus carry, write sum[idx*CHUNK +: CHUNK], update carry, and increment idx.
REQ-019 On the RUN cycle with idx == NUM_CHUNKS-1, the block SHALL go to DONE, set cout = final carry, and set ovf = (carry into MSB) ^ (carry out of MSB).
REQ-020 Latency SHALL be as follows: with accept at edge k, out_valid rises at edge k+NUM_CHUNKS; for CHUNK == WIDTH, RUN lasts exactly one cycle.
REQ-021 In DONE, sum, cout and ovf SHALL hold stable until out_valid && out_ready; at that edge the FSM goes to IDLE, and outputs keep their values until the next accept.
REQ-022 in_valid SHALL be ignored outside IDLE; there is no overlap between operations, and minimum issue period is NUM_CHUNKS+2 cycles.
REQ-023 Operands SHALL be sampled only at accept; changes on a, b, cin or sub during RUN or DONE have no effect.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; the result equals the single-cycle WIDTH-bit ripple result bit-exactly for all inputs.

Reset
REQ-025 While rst=1 at an edge, the block SHALL go to IDLE and set sum=0, cout=0, ovf=0, out_valid=0, idx=0 and carry=0; after reset, in_ready=1.
REQ-026 rst SHALL take priority over accept and handshake; reset in RUN or DONE aborts the operation, and no result is delivered.

Structure
REQ-027 Package multicycle_rca_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE); NUM_CHUNKS and the index width ($clog2 of NUM_CHUNKS, minimum 1) are derived locally from the parameters.
REQ-028 One combinational sub-module, chunk_adder, SHALL be instantiated: CHUNK-bit ripple adder of full-adder cells with inputs a, b, cin and outputs s, cout and c_msb (carry into the top bit, used for ovf).
REQ-029 The top level SHALL contain only the FSM, the registers and the chunk mux/demux; there are no combinational paths from inputs to outputs.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-030 The bench SHALL check add 0x00FF+0x0001, cin=0, accepted at edge k -> out_valid at edge k+4, sum=0x0100, cout=0, ovf=0.
REQ-031 The bench SHALL check add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0, and add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-032 The bench SHALL check sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0, and sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 The bench SHALL check that with out_ready held 0 for 10 cycles in DONE, out_valid=1, sum, cout and ovf stay constant, in_ready=0, and a second in_valid is ignored; one cycle of out_ready=1 then gives IDLE and in_ready=1.
REQ-034 The bench SHALL check that rst=1 on the second RUN cycle gives, at the next edge, IDLE with out_valid=0 and sum=0; a following add 0x1234+0x1111 gives sum=0x2345.
REQ-035 The bench SHALL check, with CHUNK=16 and CHUNK=1, a random 1000-operation add/sub sweep against a reference model: bit-exact sum, cout and ovf, and latency NUM_CHUNKS.
